// File: rtl/lm96570_spi_rx.sv
// rtl/lm96570_spi_rx.sv - LM96570 serial read-back receiver with Avalon-MM style register port
module lm96570_spi_rx #(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 4,
    parameter int SYNC_N  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        spi_sclk,
    output logic        spi_le,
    input  logic        spi_sdo,
    output logic        irq
);

    localparam int CW = $clog2(CLK_DIV + 1);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL} state_t;

    state_t              state, state_d;
    logic [CW-1:0]       cnt, cnt_d;
    logic [5:0]          bit_cnt, bit_cnt_d;
    logic [5:0]          nbits, nbits_d;
    logic [DATA_W-1:0]   sr, sr_d;
    logic [DATA_W-1:0]   rx_data, rx_data_d;
    logic                sclk_d, le_d;
    logic                done, done_d;
    logic                ovr, ovr_d;
    logic                ie, ie_d;
    logic [SYNC_N-1:0]   sdo_sync;
    logic                sdo_s;

    logic                wr_ctrl, wr_stat, rd_rx;
    logic                start_req, abort_req, last;
    logic [5:0]          wn, nbits_eff;
    logic                unused_wdata;

    assign wr_ctrl   = chipselect & ~write_n & (address == 2'd1);
    assign wr_stat   = chipselect & ~write_n & (address == 2'd2);
    assign rd_rx     = chipselect & ~read_n  & (address == 2'd0);
    assign abort_req = wr_ctrl & writedata[9];
    assign start_req = wr_ctrl & writedata[8] & ~writedata[9];
    assign wn        = writedata[5:0];
    assign nbits_eff = (wn == 6'd0 || int'(wn) > DATA_W) ? 6'(DATA_W) : wn;
    assign last      = (cnt == CW'(CLK_DIV - 1));
    assign sdo_s     = sdo_sync[SYNC_N-1];
    assign unused_wdata = ^{writedata[31:11], writedata[7:6]};

    // SDO comes from the pulser's clock domain; resynchronise before sampling
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sdo_sync <= '0;
        else
            sdo_sync <= (sdo_sync << 1) | SYNC_N'(spi_sdo);
    end

    // Next-state and register-update logic for the frame sequencer and status bits
    always_comb begin
        state_d   = state;
        cnt_d     = last ? '0 : cnt + CW'(1);
        bit_cnt_d = bit_cnt;
        nbits_d   = nbits;
        sr_d      = sr;
        rx_data_d = rx_data;
        sclk_d    = spi_sclk;
        le_d      = spi_le;
        done_d    = done;
        ovr_d     = ovr;
        ie_d      = ie;

        if (wr_ctrl)
            ie_d = writedata[10];
        if (wr_stat && writedata[2])
            ovr_d = 1'b0;
        if (rd_rx)
            done_d = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (start_req) begin
                    sr_d      = '0;
                    done_d    = 1'b0;
                    le_d      = 1'b0;
                    nbits_d   = nbits_eff;
                    bit_cnt_d = '0;
                    state_d   = S_LEAD;
                end
            end
            S_LEAD: begin
                if (last)
                    state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (last) begin
                    if (!spi_sclk) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d    = 1'b0;
                        sr_d      = (sr << 1) | DATA_W'(sdo_s);
                        bit_cnt_d = bit_cnt + 6'd1;
                        if (bit_cnt + 6'd1 == nbits)
                            state_d = S_TRAIL;
                    end
                end
            end
            S_TRAIL: begin
                if (last) begin
                    le_d      = 1'b1;
                    rx_data_d = sr;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start_req && state != S_IDLE)
            ovr_d = 1'b1;

        // Abort drops the frame but leaves the last completed word and its done flag alone
        if (abort_req) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            sclk_d    = 1'b0;
            le_d      = 1'b1;
            sr_d      = sr;
            rx_data_d = rx_data;
            done_d    = rd_rx ? 1'b0 : done;
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            nbits    <= 6'(DATA_W);
            sr       <= '0;
            rx_data  <= '0;
            spi_sclk <= 1'b0;
            spi_le   <= 1'b1;
            done     <= 1'b0;
            ovr      <= 1'b0;
            ie       <= 1'b0;
            irq      <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bit_cnt  <= bit_cnt_d;
            nbits    <= nbits_d;
            sr       <= sr_d;
            rx_data  <= rx_data_d;
            spi_sclk <= sclk_d;
            spi_le   <= le_d;
            done     <= done_d;
            ovr      <= ovr_d;
            ie       <= ie_d;
            irq      <= done_d & ie_d;
        end
    end

    // Zero-wait-state read mux; forced to zero while reset is held
    always_comb begin
        readdata = 32'd0;
        if (reset_n) begin
            case (address)
                2'd0:    readdata = 32'(rx_data);
                2'd2:    readdata = {27'd0, ie, ovr, done, (state != S_IDLE), spi_le};
                default: readdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_lm96570_spi_rx.sv
// tb/tb_lm96570_spi_rx.sv - scoreboard testbench for lm96570_spi_rx
module tb_lm96570_spi_rx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        spi_sclk;
    logic        spi_le;
    logic        spi_sdo = 1'b0;
    logic        irq;

    always #5 clk = ~clk;

    lm96570_spi_rx #(.DATA_W(32), .CLK_DIV(4), .SYNC_N(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .spi_sclk   (spi_sclk),
        .spi_le     (spi_le),
        .spi_sdo    (spi_sdo),
        .irq        (irq)
    );

    int checks = 0;
    int errors = 0;

    string       rd_nm[$];
    logic [31:0] rd_exp[$];
    string       pin_nm[$];
    logic [31:0] pin_act[$];
    logic [31:0] pin_exp[$];

    // Pulser SDO model: first bit on LE fall, next bit after each SCLK fall
    logic [31:0] pat = 32'd0;
    int          pat_n = 8;
    int          idx = 0, rises = 0, falls = 0, le_low = 0;
    logic        prev_le = 1'b1, prev_sclk = 1'b0;

    always @(posedge clk) begin
        #1;
        if (prev_le && !spi_le) begin
            idx = pat_n - 1; rises = 0; falls = 0; le_low = 0;
        end else begin
            if (!prev_sclk && spi_sclk) rises++;
            if (prev_sclk && !spi_sclk) begin
                falls++;
                if (idx > 0) idx--;
            end
        end
        if (!spi_le) le_low++;
        prev_le   = spi_le;
        prev_sclk = spi_sclk;
        spi_sdo   = pat[idx];
    end

    function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    // Monitor: drains pin observations and checks every bus read against the scoreboard
    always @(negedge clk) begin
        while (pin_nm.size() > 0)
            cmp(pin_nm.pop_front(), pin_act.pop_front(), pin_exp.pop_front());
        if (chipselect && !read_n) begin
            if (rd_nm.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got 0x%08h expected no read", readdata);
            end else begin
                cmp(rd_nm.pop_front(), readdata, rd_exp.pop_front());
            end
        end
    end

    task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
        pin_nm.push_back(nm);
        pin_act.push_back(act);
        pin_exp.push_back(exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        rd_nm.push_back(nm);
        rd_exp.push_back(e);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic frame(input logic [31:0] ctrl, input logic [31:0] p, input int n);
        pat = p; pat_n = n;
        wr(2'd1, ctrl);
    endtask

    task automatic wait_irq(output int c);
        c = 0;
        while (!irq && c < 400) begin @(posedge clk); #1; c++; end
    endtask

    // Directed stimulus; expected values are pushed ahead of each observation
    initial begin
        int c;
        logic seen;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
        address = 2'd2; writedata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        pin("rst_sclk", 32'(spi_sclk), 32'd0);
        pin("rst_le", 32'(spi_le), 32'd1);
        pin("rst_irq", 32'(irq), 32'd0);
        pin("rst_readdata", readdata, 32'd0);
        reset_n = 1'b1;
        idle(1);
        rd(2'd2, 32'h1, "init_status");
        rd(2'd0, 32'h0, "init_rxdata");
        rd(2'd3, 32'h0, "reserved_reads_0");

        // 8-bit frame, interrupt enabled
        frame(32'h508, 32'hA5, 8);
        wait_irq(c);
        pin("t1_done_latency", 32'(c), 32'd72);
        pin("t1_le_low_cycles", 32'(le_low), 32'd72);
        rd(2'd2, 32'h15, "t1_status_done");
        rd(2'd0, 32'hA5, "t1_rxdata");
        rd(2'd2, 32'h11, "t1_status_cleared");
        pin("t1_irq_cleared", 32'(irq), 32'd0);

        // 8-bit frame, interrupt disabled
        frame(32'h108, 32'h3C, 8);
        seen = 1'b0;
        repeat (80) begin @(posedge clk); #1; seen = seen | irq; end
        pin("t1b_no_irq", 32'(seen), 32'd0);
        rd(2'd2, 32'h5, "t1b_status");
        rd(2'd0, 32'h3C, "t1b_rxdata");

        // nbits=0 selects a full 32-bit frame
        frame(32'h100, 32'hDEADBEEF, 32);
        idle(270);
        pin("t2_sclk_rises", 32'(rises), 32'd32);
        pin("t2_le_low_cycles", 32'(le_low), 32'd264);
        rd(2'd2, 32'h5, "t2_status");
        rd(2'd0, 32'hDEADBEEF, "t2_rxdata");

        // Start while busy is ignored and flags overrun
        frame(32'h108, 32'h5A, 8);
        idle(20);
        wr(2'd1, 32'h104);
        idle(60);
        pin("t3_sclk_rises", 32'(rises), 32'd8);
        rd(2'd2, 32'hD, "t3_status_ovr");
        rd(2'd0, 32'h5A, "t3_rxdata");
        wr(2'd2, 32'h4);
        rd(2'd2, 32'h1, "t3_ovr_cleared");

        // Abort after three bits
        frame(32'h108, 32'hFF, 8);
        c = 0;
        while (falls < 3 && c < 200) begin idle(1); c++; end
        pin("t4_reached_3_bits", 32'(c < 200), 32'd1);
        wr(2'd1, 32'h200);
        pin("t4_abort_sclk", 32'(spi_sclk), 32'd0);
        pin("t4_abort_le", 32'(spi_le), 32'd1);
        rd(2'd2, 32'h1, "t4_status_idle");
        rd(2'd0, 32'h5A, "t4_rxdata_kept");
        frame(32'h508, 32'h81, 8);
        wait_irq(c);
        pin("t4_restart_latency", 32'(c), 32'd72);
        rd(2'd0, 32'h81, "t4_restart_rxdata");

        // RXDATA read coinciding with done being set
        frame(32'h508, 32'h96, 8);
        idle(71);
        rd(2'd0, 32'h81, "t5_read_at_done");
        rd(2'd2, 32'h15, "t5_done_kept");
        rd(2'd0, 32'h96, "t5_rxdata");
        rd(2'd2, 32'h11, "t5_done_cleared");

        // Reset in the middle of SHIFT
        frame(32'h508, 32'hFF, 8);
        idle(10);
        wr(2'd1, 32'h508);
        c = 0;
        while (!(spi_sclk && rises >= 2) && c < 200) begin idle(1); c++; end
        pin("t6_pre_sclk_high", 32'(spi_sclk), 32'd1);
        pin("t6_pre_le_low", 32'(spi_le), 32'd0);
        reset_n = 1'b0;
        #1;
        pin("t6_rst_sclk", 32'(spi_sclk), 32'd0);
        pin("t6_rst_le", 32'(spi_le), 32'd1);
        pin("t6_rst_irq", 32'(irq), 32'd0);
        address = 2'd2;
        #1;
        pin("t6_rst_status_rd", readdata, 32'd0);
        address = 2'd0;
        #1;
        pin("t6_rst_rxdata_rd", readdata, 32'd0);
        idle(2);
        reset_n = 1'b1;
        idle(1);
        rd(2'd2, 32'h1, "t6_status_after");
        rd(2'd0, 32'h0, "t6_rxdata_after");

        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
